imm_gen_stage: RTL

// - Registered, parametrised immediate-generation stage between fetch and execute.
// - Accepts one instruction word per cycle with a tag over valid/ready.
// - Emits the XLEN-wide extended immediate, an immediate-class code and an illegal flag.
// - A 2-entry skid buffer sustains full throughput while in_ready stays a pure register output.
// - Adds beyond the single-cycle generator: RV64 support, CSR zimm, shift-amount class, flush.

---
 rtl/imm_pkg.sv | 32 +++
 rtl/imm_extract.sv | 95 +++++++++
 rtl/imm_gen_stage.sv | 130 +++++++++++++
 3 files changed

// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the immediate-generation stage.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_SH   = 3'd6,
        IMM_Z    = 3'd7
    } imm_type_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_OPIMM   = 7'b0010011;
    localparam logic [6:0] OP_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OP_OP      = 7'b0110011;
    localparam logic [6:0] OP_OP32    = 7'b0111011;
    localparam logic [6:0] OP_SYSTEM  = 7'b1110011;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate decode: instruction word to extended immediate, class and illegal flag.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_type_e       imm_type,
    output logic            illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] raw;
    logic        sext;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    // raw holds a 32-bit immediate; sext selects how it widens to XLEN
    always_comb begin
        raw      = '0;
        sext     = 1'b0;
        imm_type = IMM_NONE;
        illegal  = 1'b0;
        if (instr[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (opcode)
                OP_STORE: begin
                    raw      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                    sext     = 1'b1;
                    imm_type = IMM_S;
                end
                OP_BRANCH: begin
                    raw      = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                    sext     = 1'b1;
                    imm_type = IMM_B;
                end
                OP_LUI, OP_AUIPC: begin
                    raw      = {instr[31:12], 12'b0};
                    sext     = 1'b1;
                    imm_type = IMM_U;
                end
                OP_JAL: begin
                    raw      = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                    sext     = 1'b1;
                    imm_type = IMM_J;
                end
                OP_OPIMM: begin
                    if (funct3[1:0] == 2'b01) begin
                        raw      = (XLEN == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
                        imm_type = IMM_SH;
                    end else begin
                        raw      = {{20{instr[31]}}, instr[31:20]};
                        sext     = 1'b1;
                        imm_type = IMM_I;
                    end
                end
                OP_OPIMM32: begin
                    if ((XLEN == 64) && (funct3[1:0] == 2'b01)) begin
                        raw      = {27'b0, instr[24:20]};
                        imm_type = IMM_SH;
                    end else begin
                        raw      = {{20{instr[31]}}, instr[31:20]};
                        sext     = 1'b1;
                        imm_type = IMM_I;
                    end
                end
                OP_SYSTEM: begin
                    if (funct3[2]) begin
                        raw      = {27'b0, instr[19:15]};
                        imm_type = IMM_Z;
                    end else begin
                        raw      = {{20{instr[31]}}, instr[31:20]};
                        sext     = 1'b1;
                        imm_type = IMM_I;
                    end
                end
                OP_OP, OP_OP32: begin
                    imm_type = IMM_NONE;
                end
                default: begin
                    raw      = {{20{instr[31]}}, instr[31:20]};
                    sext     = 1'b1;
                    imm_type = IMM_I;
                end
            endcase
        end
    end

    assign imm = sext ? XLEN'($signed(raw)) : XLEN'(raw);

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage with a 2-entry skid buffer; in_ready and out_valid are flops.
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output imm_type_e        out_type,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
        $fatal(1, "imm_gen_stage: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0]  dec_imm;
    imm_type_e        dec_type;
    logic             dec_illegal;

    logic [XLEN-1:0]  skid_imm;
    imm_type_e        skid_type;
    logic             skid_illegal;
    logic [TAG_W-1:0] skid_tag;

    buf_state_e state, state_next;
    logic       accept, drain;
    logic       load_main_in, load_main_skid, load_skid;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr    (in_instr),
        .imm      (dec_imm),
        .imm_type (dec_type),
        .illegal  (dec_illegal)
    );

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_next = BUF_EMPTY;
        end else begin
            case (state)
                BUF_EMPTY: begin
                    if (accept) begin
                        state_next   = BUF_ONE;
                        load_main_in = 1'b1;
                    end
                end
                BUF_ONE: begin
                    if (accept && drain) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_next = BUF_FULL;
                        load_skid  = 1'b1;
                    end else if (drain) begin
                        state_next = BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (drain) begin
                        state_next     = BUF_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_next = BUF_EMPTY;
            endcase
        end
    end

    // Handshake flags are registered from the next state so neither depends on live inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BUF_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next != BUF_FULL);
            out_valid <= (state_next != BUF_EMPTY);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_imm      <= '0;
            out_type     <= IMM_NONE;
            out_illegal  <= 1'b0;
            out_tag      <= '0;
            skid_imm     <= '0;
            skid_type    <= IMM_NONE;
            skid_illegal <= 1'b0;
            skid_tag     <= '0;
        end else begin
            if (load_main_in) begin
                out_imm     <= dec_imm;
                out_type    <= dec_type;
                out_illegal <= dec_illegal;
                out_tag     <= in_tag;
            end else if (load_main_skid) begin
                out_imm     <= skid_imm;
                out_type    <= skid_type;
                out_illegal <= skid_illegal;
                out_tag     <= skid_tag;
            end
            if (load_skid) begin
                skid_imm     <= dec_imm;
                skid_type    <= dec_type;
                skid_illegal <= dec_illegal;
                skid_tag     <= in_tag;
            end
        end
    end

endmodule
